// File: rtl/stopwatch_sequencer.sv
// Run/pause/lap/clear sequencer for the stopwatch: button conditioning, control FSM,
// centisecond tick prescaler and display freeze.
module stopwatch_sequencer #(
  parameter int unsigned CLK_HZ          = 100_000_000,
  parameter int unsigned TICK_HZ         = 100,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_lap_reset,
  output logic       count_enable,
  output logic       count_tick,
  output logic       count_clear,
  output logic       display_freeze,
  output logic [1:0] state
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  // Bit 0 is start/stop, bit 1 is lap/reset.
  logic [1:0]    raw_c;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    level;
  logic [1:0]    level_d;
  logic [1:0]    press;
  logic [DW-1:0] db_cnt [2];

  assign raw_c = {btn_lap_reset, btn_start_stop};

  // Two-stage synchronizer, per-button debounce counter and registered rising-edge press pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_d <= '0;
      press   <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1   <= raw_c;
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          level[i]  <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  state_t     state_q;
  state_t     state_d;
  logic       enable_d;
  logic       freeze_d;
  logic       clear_d;
  logic       ss_c;
  logic       lr_c;
  logic [PW-1:0] pre;
  logic       wrap_c;

  assign ss_c   = press[0];
  assign lr_c   = press[1];
  assign wrap_c = (pre == PW'(DIV - 1));

  // Next-state and next-output decode; start/stop wins over a simultaneous lap/reset.
  always_comb begin
    state_d = state_q;
    clear_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_c)      state_d = RUN;
        else if (lr_c) clear_d = 1'b1;
      end
      RUN: begin
        if (ss_c)      state_d = PAUSE;
        else if (lr_c) state_d = LAP;
      end
      LAP: begin
        if (ss_c)      state_d = PAUSE;
        else if (lr_c) state_d = RUN;
      end
      PAUSE: begin
        if (ss_c) begin
          state_d = RUN;
        end else if (lr_c) begin
          state_d = IDLE;
          clear_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    enable_d = (state_d == RUN) || (state_d == LAP);
    freeze_d = (state_d == LAP);
  end

  // State register, registered outputs and tick prescaler (held while paused).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      count_enable   <= 1'b0;
      display_freeze <= 1'b0;
      count_clear    <= 1'b1;
      count_tick     <= 1'b0;
      pre            <= '0;
    end else begin
      state_q        <= state_d;
      count_enable   <= enable_d;
      display_freeze <= freeze_d;
      count_clear    <= clear_d;
      // A wrap coinciding with enable dropping is not reported as a tick.
      count_tick     <= count_enable & enable_d & wrap_c;
      if (clear_d)           pre <= '0;
      else if (count_enable) pre <= wrap_c ? '0 : pre + PW'(1);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_stopwatch_sequencer.sv
// Directed bench for stopwatch_sequencer with an expected-result queue per button press.
module tb_stopwatch_sequencer;

  localparam int unsigned DEB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_start_stop = 1'b0;
  logic       btn_lap_reset = 1'b0;
  logic       count_enable;
  logic       count_tick;
  logic       count_clear;
  logic       display_freeze;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_change = 0;
  int clr_cnt = 0;
  int tick_q[$];

  typedef struct {
    logic [1:0] st;
    logic       en;
    logic       frz;
    logic       clr;
  } exp_t;

  exp_t exp_q[$];

  stopwatch_sequencer #(
    .CLK_HZ(1000),
    .TICK_HZ(100),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_start_stop(btn_start_stop),
    .btn_lap_reset(btn_lap_reset),
    .count_enable(count_enable),
    .count_tick(count_tick),
    .count_clear(count_clear),
    .display_freeze(display_freeze),
    .state(state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Tick timestamps, clear-pulse count and the tick-implies-enable rule.
  always @(negedge clk) begin
    if (!reset) begin
      if (count_tick) tick_q.push_back(cyc);
      if (count_clear) clr_cnt++;
      checks++;
      assert (!(count_tick && !count_enable)) else begin
        errors++;
        $error("FAIL tick_without_enable observed=1 expected=0 cycle=%0d", cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input logic [1:0] st, input logic en, input logic frz, input logic clr);
    exp_t e;
    e.st = st; e.en = en; e.frz = frz; e.clr = clr;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int tick_at(input int i, input int base);
    return (i < tick_q.size()) ? tick_q[i] - base : -1;
  endfunction

  // Hold the given buttons until the DUT reacts, compare against the queued expectation,
  // then release and confirm the release produces no further change.
  task automatic do_press(input string tag, input logic ss, input logic lr, input exp_t e);
    exp_t       got;
    logic [1:0] st0;
    int         lat;
    st0 = state;
    exp_q.push_back(e);
    btn_start_stop = ss;
    btn_lap_reset  = lr;
    lat = 0;
    do begin
      step();
      lat++;
    end while (state == st0 && !count_clear && lat < 30);
    t_change = cyc;
    got = exp_q.pop_front();
    chk({tag, "_latency"}, lat, 8);
    chk({tag, "_state"}, state, got.st);
    chk({tag, "_enable"}, count_enable, got.en);
    chk({tag, "_freeze"}, display_freeze, got.frz);
    chk({tag, "_clear"}, count_clear, got.clr);
    btn_start_stop = 1'b0;
    btn_lap_reset  = 1'b0;
    repeat (DEB + 4) step();
    chk({tag, "_hold"}, state, got.st);
  endtask

  int e_run, p_pause, r_run, e2_run, n_ticks, clr_snap;

  initial begin
    // 1: reset values
    reset = 1'b1;
    repeat (3) step();
    chk("rst_clear", count_clear, 1);
    chk("rst_enable", count_enable, 0);
    chk("rst_tick", count_tick, 0);
    chk("rst_freeze", display_freeze, 0);
    chk("rst_state", state, 0);
    reset = 1'b0;
    step();
    chk("rel_clear", count_clear, 0);

    // 2: short bounces are ignored, then a stable press enters RUN
    tick_q.delete();
    btn_start_stop = 1'b1; step();
    btn_start_stop = 1'b0; step();
    btn_start_stop = 1'b1; step();
    btn_start_stop = 1'b0; step();
    chk("bounce_state", state, 0);
    do_press("start", 1'b1, 1'b0, mk(2'd1, 1'b1, 1'b0, 1'b0));
    e_run = t_change;

    // 3: three ticks, pause keeps the partial period, resume finishes it
    while (cyc < e_run + 27) step();
    do_press("pause", 1'b1, 1'b0, mk(2'd2, 1'b0, 1'b0, 1'b0));
    p_pause = t_change;
    chk("pause_at_35", p_pause - e_run, 35);
    chk("ticks_before_pause", tick_q.size(), 3);
    for (int i = 0; i < 3; i++) chk("tick_spacing", tick_at(i, e_run), 10 * (i + 1));
    while (cyc < p_pause + 12) step();
    do_press("resume", 1'b1, 1'b0, mk(2'd1, 1'b1, 1'b0, 1'b0));
    r_run = t_change;
    chk("pause_length", r_run - p_pause, 20);
    while (cyc < r_run + 12) step();
    chk("ticks_after_resume", tick_q.size(), 4);
    chk("resume_tick", tick_at(3, r_run), 5);

    // 4: lap freeze, unfreeze, lap then pause
    do_press("lap", 1'b0, 1'b1, mk(2'd3, 1'b1, 1'b1, 1'b0));
    n_ticks = tick_q.size();
    repeat (12) step();
    chk("lap_ticks_continue", tick_q.size() > n_ticks, 1);
    do_press("unlap", 1'b0, 1'b1, mk(2'd1, 1'b1, 1'b0, 1'b0));
    do_press("lap2", 1'b0, 1'b1, mk(2'd3, 1'b1, 1'b1, 1'b0));
    do_press("lap_pause", 1'b1, 1'b0, mk(2'd2, 1'b0, 1'b0, 1'b0));

    // 5: clear from PAUSE and from IDLE, then prescaler starts from zero
    do_press("clr_pause", 1'b0, 1'b1, mk(2'd0, 1'b0, 1'b0, 1'b1));
    do_press("clr_idle", 1'b0, 1'b1, mk(2'd0, 1'b0, 1'b0, 1'b1));
    tick_q.delete();
    do_press("restart", 1'b1, 1'b0, mk(2'd1, 1'b1, 1'b0, 1'b0));
    e2_run = t_change;
    while (cyc < e2_run + 12) step();
    chk("restart_ticks", tick_q.size(), 1);
    chk("restart_first_tick", tick_at(0, e2_run), 10);

    // 6: simultaneous presses, then reset in the middle of a debounce
    do_press("both", 1'b1, 1'b1, mk(2'd2, 1'b0, 1'b0, 1'b0));
    btn_start_stop = 1'b1;
    repeat (3) step();
    reset = 1'b1;
    btn_start_stop = 1'b0;
    repeat (2) step();
    chk("midrst_state", state, 0);
    chk("midrst_clear", count_clear, 1);
    chk("midrst_enable", count_enable, 0);
    reset = 1'b0;
    step();
    chk("midrst_rel_clear", count_clear, 0);
    clr_snap = clr_cnt;
    repeat (20) step();
    chk("midrst_no_press", state, 0);
    chk("midrst_no_clear", clr_cnt, clr_snap);
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
